// File: rtl/seq_mult_32b.sv
// seq_mult_32b: sequential shift-and-add unsigned multiplier.
// Adds one partial product per clock over WIDTH cycles. The latency is fixed
// at WIDTH cycles, with no early exit for small operands.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-high reset; clears all state and outputs
//   start    request to multiply a by b; accepted in IDLE or DONE
//   a, b     unsigned operands, captured only when start is accepted
//   busy     high while iterating (CALC)
//   done     one-cycle completion pulse (DONE)
//   product  registered full 2*WIDTH-bit product; holds the last result
//   result   low half of product; feeds the ALU result mux
//   overflow registered; set when the upper half of product is non-zero
module seq_mult_32b #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   result,
  output logic               overflow
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               overflow_q, overflow_d;
  logic [2*WIDTH-1:0] acc_sum;

  // The accumulator is as wide as the full product, so this add cannot carry out.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    count_d    = count_q;
    product_d  = product_q;
    overflow_d = overflow_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = StCalc;
        end else begin
          state_d = StIdle;
        end
      end
      StCalc: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CntW'(1);
        if (count_q == CntW'(WIDTH - 1)) begin
          // The final iteration's add is included in the stored product.
          product_d  = acc_sum;
          overflow_d = |acc_sum[2*WIDTH-1:WIDTH];
          state_d    = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      count_q    <= '0;
      product_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      count_q    <= count_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q == StCalc);
  assign done     = (state_q == StDone);
  assign product  = product_q;
  assign result   = product_q[WIDTH-1:0];
  assign overflow = overflow_q;

endmodule

// File: tb/tb_seq_mult_32b.sv
// Scoreboard bench for seq_mult_32b: stimulus pushes expected products,
// and a negedge monitor pops and compares them whenever done is high.
module tb_seq_mult_32b;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  a, b;
  logic          busy, done, overflow;
  logic [2*W-1:0] product;
  logic [W-1:0]  result;

  seq_mult_32b #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product), .result(result),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] p;
    int             acc_edge;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int busy_cnt = 0;
  logic [2*W-1:0] last_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops and checks on every done; also checks output stability while busy.
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) begin
        busy_cnt++;
        chk("product_stable_in_calc", product, last_exp);
        chk("result_stable_in_calc", {{W{1'b0}}, result}, {{W{1'b0}}, last_exp[W-1:0]});
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("product", product, e.p);
          chk("result", {{W{1'b0}}, result}, {{W{1'b0}}, e.p[W-1:0]});
          chk("overflow", {63'd0, overflow}, {63'd0, (e.p >> W) != 0});
          chk("latency", 64'(cyc - e.acc_edge), 64'(W));
          last_exp = e.p;
        end
        chk("busy_len", 64'(busy_cnt), 64'(W));
        chk("busy_low_in_done", {63'd0, busy}, 64'd0);
        busy_cnt = 0;
      end
    end
  end

  // All stimulus tasks are entered and left at a negedge.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    start = 1'b1;
    a = x;
    b = y;
    e.p = 64'(x) * 64'(y);
    e.acc_edge = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3 * W; i++) begin
      if (done) return;
      @(negedge clk);
    end
    chk("done_timeout", 64'd1, 64'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_product"}, product, 64'd0);
    chk({tag, "_result"}, {{W{1'b0}}, result}, 64'd0);
    chk({tag, "_overflow"}, {63'd0, overflow}, 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    issue(3, 5);                      wait_done(); @(negedge clk);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done(); @(negedge clk);
    issue(0, 32'hDEAD_BEEF);          wait_done(); @(negedge clk);
    issue(1, 32'h8000_0000);          wait_done(); @(negedge clk);

    // Start while busy: second request must be ignored.
    issue(7, 9);
    repeat (9) @(negedge clk);
    start = 1'b1; a = 2; b = 2;
    @(negedge clk);
    start = 1'b0;
    wait_done(); @(negedge clk);

    // Reset mid-operation discards the pending result.
    issue(100, 200);
    repeat (14) @(negedge clk);
    #1 reset = 1'b1;
    q.delete();
    last_exp = '0;
    #1 chk_zero_outputs("async_reset");
    @(negedge clk);
    @(negedge clk);
    chk_zero_outputs("mid_reset");
    reset = 1'b0;
    @(negedge clk);
    issue(4, 6);                      wait_done(); @(negedge clk);

    // Back-to-back: start held during DONE.
    issue(6, 7);
    wait_done();
    issue(32'h1_0000, 32'h1_0000);
    wait_done(); @(negedge clk);

    // Random operations, some chained back-to-back.
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] x, y;
      x = $urandom;
      y = (i % 4 == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
      issue(x, y);
      wait_done();
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
    wait_done();
    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_mult_32b.md
# seq_mult_32b

Sequential shift-and-add unsigned multiplier that produces the MUL result for the ALU. It computes one partial product per clock over WIDTH cycles. The low half of its registered product drives the multiplier input of the ALU's 32-bit 8:1 result mux. The high half and an overflow flag are available to the status logic.

## Interface
- WIDTH, 32, operand width; also the number of iteration cycles (counter sized to hold WIDTH-1)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state and outputs
- start  input  1  request to multiply a by b; sampled on rising edge
- a  input  WIDTH  multiplicand, unsigned; captured only when start is accepted
- b  input  WIDTH  multiplier, unsigned; captured only when start is accepted
- busy  output  1  high while an operation is in progress (CALC state)
- done  output  1  one-cycle pulse, high in DONE state
- product  output  2*WIDTH  registered full product; holds the last completed result
- result  output  WIDTH  product[WIDTH-1:0]; feeds the ALU result mux
- overflow  output  1  registered; 1 when product[2*WIDTH-1:WIDTH] != 0

## Operation
- States: IDLE, CALC, DONE. Reset state is IDLE.
- Reset values: busy=0, done=0, product=0, result=0, overflow=0. Internal acc, mcand, mplier and count are all 0.
- IDLE or DONE with start=1 at an edge: accept.
  - mcand <= {WIDTH'b0, a}; mplier <= b; acc <= 0; count <= 0.
  - State goes to CALC.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE.
- CALC, at every edge:
  - If mplier[0]=1, acc <= acc + mcand. The sum is 2*WIDTH bits wide and cannot overflow.
  - mcand <= mcand << 1; mplier <= mplier >> 1; count <= count + 1.
- CALC with count = WIDTH-1:
  - The final iteration executes.
  - product <= final acc value, including this iteration's add.
  - overflow <= (upper half of final acc != 0).
  - State goes to DONE.
- No early termination: latency is fixed regardless of operand values.
- start while in CALC is ignored. a and b are not re-sampled, and the operation continues unaffected.
- product, result and overflow change only on completion or reset. They are stable during CALC and show the previous result.
- Reset asserted mid-operation:
  - Immediate return to IDLE with all outputs at 0.
  - The partial result is discarded and no done pulse is generated.

## Timing
- start accepted at edge k:
  - busy=1 from edge k to edge k+WIDTH.
  - Iterations run on edges k+1 .. k+WIDTH.
  - product, result and overflow are valid from edge k+WIDTH.
  - done=1 from edge k+WIDTH to edge k+WIDTH+1; busy is 0 during done.
- Latency for WIDTH=32: result is visible 32 cycles after the accepting edge.
- Back-to-back: start=1 during DONE is accepted at edge k+WIDTH+1, so there are no idle cycles between operations. done stays high for exactly one cycle.
- No combinational path from inputs to outputs. result is a direct slice of the product register.
- Async reset takes effect without a clock edge. Deassertion is synchronous to the system; the first start may be sampled at the first edge after deassertion.

## Test plan
- Basic multiply:
  - Stimulus: a=3, b=5, one-cycle start.
  - Required: after 32 cycles, done pulses once, product=15, result=15, overflow=0.
  - Required: busy high for exactly 32 cycles.
- Max operands:
  - Stimulus: a=b=0xFFFFFFFF.
  - Required: product=0xFFFFFFFE00000001, result=0x00000001, overflow=1.
- Zero and identity:
  - Stimulus: 0 x 0xDEADBEEF.
  - Required: product=0, overflow=0.
  - Stimulus: 1 x 0x80000000.
  - Required: result=0x80000000, overflow=0.
  - Required: latency is still 32 cycles in both cases.
- Start while busy:
  - Stimulus: start 7 x 9, then at cycle 10 assert start with a=2, b=2.
  - Required: second request ignored, product=63, done pulses exactly once.
- Reset mid-operation:
  - Stimulus: start 100 x 200, assert reset at cycle 15 for 2 cycles.
  - Required: all outputs 0, no done pulse.
  - Stimulus: then 4 x 6.
  - Required: product=24.
- Back-to-back:
  - Stimulus: 6 x 7, with start held high in the DONE cycle and a=0x10000, b=0x10000.
  - Required: first product=42 with done pulse.
  - Required: second operation starts with no gap and completes 33 cycles after the first done.
  - Required: second result: product=0x100000000, result=0, overflow=1.
  - Required: result holds 42 throughout the second CALC.
